// File: rtl/boot_loader_arbiter_if.sv
// rtl/boot_loader_arbiter_if.sv - host load, core and memory bus bundle for boot_loader_arbiter
//
// Purpose: groups the host load handshake, the core-side memory bus and the
// memory-side bus into one bundle.
// Modports:
//   slave  - the arbiter: takes ld_* and cpu_* requests plus mem_ReadData;
//            drives ld_ready, cpu_reset, cpu_ReadData and mem_* requests.
//   master - the surroundings (host, core, memory): the mirror image.
interface boot_loader_arbiter_if;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;

  logic        cpu_reset;
  logic [31:0] cpu_Adr;
  logic [31:0] cpu_WriteData;
  logic        cpu_MemWrite;
  logic [31:0] cpu_ReadData;

  logic [31:0] mem_Adr;
  logic [31:0] mem_WriteData;
  logic        mem_MemWrite;
  logic [31:0] mem_ReadData;

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last,
    input  cpu_Adr, cpu_WriteData, cpu_MemWrite,
    input  mem_ReadData,
    output ld_ready, cpu_reset, cpu_ReadData,
    output mem_Adr, mem_WriteData, mem_MemWrite
  );

  modport master (
    output ld_start, ld_valid, ld_data, ld_last,
    output cpu_Adr, cpu_WriteData, cpu_MemWrite,
    output mem_ReadData,
    input  ld_ready, cpu_reset, cpu_ReadData,
    input  mem_Adr, mem_WriteData, mem_MemWrite
  );
endinterface

// File: rtl/boot_loader_arbiter.sv
// rtl/boot_loader_arbiter.sv - boot sequencer owning the unified memory port of the arm core
//
// Purpose: holds the core in reset while a host streams a program into memory,
// then releases the core and hands it the memory port. ld_start at any time
// re-parks the core and restarts the load.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   bus         - slave side of boot_loader_arbiter_if (load, core, memory buses)
//   busy        - loading or releasing
//   done        - core running
//   err         - load overflowed the window without ld_last
//   word_count  - words written in the current or last load
module boot_loader_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64,
  localparam int         WCW       = $clog2(MAX_WORDS) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  boot_loader_arbiter_if.slave   bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [WCW-1:0]         word_count
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [WCW-1:0] LAST_IDX = WCW'(MAX_WORDS - 1);

  state_t         state_q, state_d;
  logic [WCW-1:0] word_count_q, word_count_d;
  logic           rel_cnt_q, rel_cnt_d;
  logic           cpu_reset_q, ld_ready_q, busy_q, done_q, err_q;
  logic           accept;
  logic [31:0]    load_adr;

  // ld_start wins over a simultaneous word, so a restart never writes.
  assign accept = (state_q == S_LOAD) && bus.ld_valid && !bus.ld_start;

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    rel_cnt_d    = rel_cnt_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          word_count_d = word_count_q + 1'b1;
          if (bus.ld_last) begin
            state_d = S_RELEASE;
          end else if (word_count_q == LAST_IDX) begin
            state_d = S_ERROR;
          end
        end
      end
      S_RELEASE: begin
        if (rel_cnt_q) begin
          state_d = S_RUN;
        end else begin
          rel_cnt_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (bus.ld_start) begin
      state_d      = S_LOAD;
      word_count_d = '0;
    end
    if (state_d == S_RELEASE && state_q != S_RELEASE) begin
      rel_cnt_d = 1'b0;
    end
  end

  // Status flags are registered from the next state so they line up with the
  // state they describe; the core leaves reset only once RUN is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_WAIT;
      word_count_q <= '0;
      rel_cnt_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      ld_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      rel_cnt_q    <= rel_cnt_d;
      cpu_reset_q  <= (state_d != S_RUN);
      ld_ready_q   <= (state_d == S_LOAD);
      busy_q       <= (state_d == S_LOAD) || (state_d == S_RELEASE);
      done_q       <= (state_d == S_RUN);
      err_q        <= (state_d == S_ERROR);
    end
  end

  assign load_adr = BASE_ADDR + (32'(word_count_q) << 2);

  // In RUN the core owns the port, except that a restart request blocks its
  // store in the same cycle so nothing lands after the core is re-parked.
  always_comb begin
    bus.mem_Adr       = load_adr;
    bus.mem_WriteData = bus.ld_data;
    bus.mem_MemWrite  = accept;
    if (state_q == S_RUN) begin
      bus.mem_Adr       = bus.cpu_Adr;
      bus.mem_WriteData = bus.cpu_WriteData;
      bus.mem_MemWrite  = bus.cpu_MemWrite && !bus.ld_start;
    end
  end

  assign bus.cpu_ReadData = bus.mem_ReadData;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.ld_ready     = ld_ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign word_count       = word_count_q;

endmodule

// File: tb/tb_boot_loader_arbiter.sv
// tb/tb_boot_loader_arbiter.sv - self-checking bench for boot_loader_arbiter
module tb_boot_loader_arbiter;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;

  localparam int PH_WAIT = 0, PH_LOAD = 1, PH_REL = 2, PH_RUN = 3, PH_ERR = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy, done, err;
  logic [2:0] word_count;

  int tests = 0;
  int fails = 0;
  int n_writes = 0;

  boot_loader_arbiter_if bus();

  boot_loader_arbiter #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  assign bus.mem_ReadData = ~bus.mem_Adr;

  logic [31:0] tb_mem [logic [31:0]];

  function automatic logic [31:0] rd(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset && bus.mem_MemWrite) begin
      tb_mem[bus.mem_Adr] = bus.mem_WriteData;
      n_writes++;
    end
  end

  // Behavioural model: phase, words loaded, release cycles remaining.
  int m_phase = PH_WAIT;
  int m_count = 0;
  int m_rel   = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = PH_WAIT;
      m_count = 0;
      m_rel   = 0;
    end else begin
      if (m_phase == PH_LOAD && bus.ld_valid && !bus.ld_start) begin
        m_count++;
        if (bus.ld_last) begin
          m_phase = PH_REL;
          m_rel   = 2;
        end else if (m_count == MAXW) begin
          m_phase = PH_ERR;
        end
      end else if (m_phase == PH_REL) begin
        m_rel--;
        if (m_rel == 0) m_phase = PH_RUN;
      end
      if (bus.ld_start) begin
        m_phase = PH_LOAD;
        m_count = 0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic        e_we;
    logic [31:0] e_adr, e_dat;
    if (!reset) begin
      if (m_phase == PH_RUN) begin
        e_adr = bus.cpu_Adr;
        e_dat = bus.cpu_WriteData;
        e_we  = bus.cpu_MemWrite && !bus.ld_start;
      end else begin
        e_adr = BASE + 32'(4 * m_count);
        e_dat = bus.ld_data;
        e_we  = (m_phase == PH_LOAD) && bus.ld_valid && !bus.ld_start;
      end
      chk("cpu_reset", {31'b0, bus.cpu_reset}, {31'b0, m_phase != PH_RUN});
      chk("ld_ready", {31'b0, bus.ld_ready}, {31'b0, m_phase == PH_LOAD});
      chk("busy", {31'b0, busy}, {31'b0, m_phase == PH_LOAD || m_phase == PH_REL});
      chk("done", {31'b0, done}, {31'b0, m_phase == PH_RUN});
      chk("err", {31'b0, err}, {31'b0, m_phase == PH_ERR});
      chk("word_count", 32'(word_count), 32'(m_count));
      chk("mem_MemWrite", {31'b0, bus.mem_MemWrite}, {31'b0, e_we});
      chk("mem_Adr", bus.mem_Adr, e_adr);
      chk("mem_WriteData", bus.mem_WriteData, e_dat);
      chk("cpu_ReadData", bus.cpu_ReadData, ~bus.mem_Adr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, {31'b0, bus.cpu_reset}, 32'd1);
    chk({tag, "_ld_ready"}, {31'b0, bus.ld_ready}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    chk({tag, "_mem_MemWrite"}, {31'b0, bus.mem_MemWrite}, 32'd0);
    chk({tag, "_mem_Adr"}, bus.mem_Adr, BASE);
  endtask

  initial begin
    bus.ld_start      = 1'b0;
    bus.ld_valid      = 1'b0;
    bus.ld_data       = 32'h0;
    bus.ld_last       = 1'b0;
    bus.cpu_Adr       = 32'h0;
    bus.cpu_WriteData = 32'h0;
    bus.cpu_MemWrite  = 1'b0;

    #2 reset = 1'b1;
    #1 chk_reset_vals("rst");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Basic 4-word program load.
    n_writes = 0;
    start();
    send(32'hE3A0_0005, 1'b0);
    send(32'hE280_1001, 1'b0);
    send(32'hE580_1010, 1'b0);
    send(32'hEAFF_FFFE, 1'b1);
    chk("rel1_cpu_reset", {31'b0, bus.cpu_reset}, 32'd1);
    chk("rel1_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("rel2_cpu_reset", {31'b0, bus.cpu_reset}, 32'd1);
    tick();
    chk("run_cpu_reset", {31'b0, bus.cpu_reset}, 32'd0);
    chk("run_done", {31'b0, done}, 32'd1);
    chk("load1_count", 32'(word_count), 32'd4);
    chk("load1_writes", 32'(n_writes), 32'd4);
    chk("mem00", rd(32'h00), 32'hE3A0_0005);
    chk("mem04", rd(32'h04), 32'hE280_1001);
    chk("mem08", rd(32'h08), 32'hE580_1010);
    chk("mem0C", rd(32'h0C), 32'hEAFF_FFFE);

    // Core pass-through, then restart while the core stores.
    bus.cpu_Adr       = 32'h40;
    bus.cpu_WriteData = 32'h1234;
    bus.cpu_MemWrite  = 1'b1;
    #1;
    chk("pt_adr", bus.mem_Adr, 32'h40);
    chk("pt_data", bus.mem_WriteData, 32'h1234);
    chk("pt_we", {31'b0, bus.mem_MemWrite}, 32'd1);
    tick();
    chk("pt_mem40", rd(32'h40), 32'h1234);
    bus.ld_start = 1'b1;
    #1 chk("restart_we_blocked", {31'b0, bus.mem_MemWrite}, 32'd0);
    tick();
    bus.ld_start     = 1'b0;
    bus.cpu_MemWrite = 1'b0;
    chk("restart_cpu_reset", {31'b0, bus.cpu_reset}, 32'd1);
    chk("restart_ld_ready", {31'b0, bus.ld_ready}, 32'd1);
    chk("restart_count", 32'(word_count), 32'd0);

    // Gapped load: one word on, two cycles off.
    n_writes = 0;
    for (int i = 0; i < 3; i++) begin
      send(32'h1111_1111 * (i + 1), i == 2);
      if (i < 2) begin
        tick();
        chk("gap_ld_ready", {31'b0, bus.ld_ready}, 32'd1);
        tick();
      end
    end
    tick();
    tick();
    chk("gap_writes", 32'(n_writes), 32'd3);
    chk("gap_mem00", rd(32'h00), 32'h1111_1111);
    chk("gap_mem04", rd(32'h04), 32'h2222_2222);
    chk("gap_mem08", rd(32'h08), 32'h3333_3333);
    chk("gap_done", {31'b0, done}, 32'd1);
    chk("gap_count", 32'(word_count), 32'd3);

    // Restart mid-load with a simultaneous word.
    start();
    send(32'hA0, 1'b0);
    send(32'hA1, 1'b0);
    chk("mid_count2", 32'(word_count), 32'd2);
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hBAD;
    #1 chk("mid_no_write", {31'b0, bus.mem_MemWrite}, 32'd0);
    tick();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    chk("mid_count0", 32'(word_count), 32'd0);

    // Overflow: four words without ld_last.
    n_writes = 0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hD0;
    #1 chk("ovf_first_adr", bus.mem_Adr, BASE);
    tick();
    bus.ld_valid = 1'b0;
    send(32'hD1, 1'b0);
    send(32'hD2, 1'b0);
    send(32'hD3, 1'b0);
    chk("ovf_err", {31'b0, err}, 32'd1);
    chk("ovf_cpu_reset", {31'b0, bus.cpu_reset}, 32'd1);
    chk("ovf_count", 32'(word_count), 32'd4);
    chk("ovf_writes", 32'(n_writes), 32'd4);
    chk("ovf_mem00", rd(32'h00), 32'hD0);
    chk("ovf_mem0C", rd(32'h0C), 32'hD3);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hEE;
    repeat (3) tick();
    bus.ld_valid = 1'b0;
    chk("err_ignore_writes", 32'(n_writes), 32'd4);
    chk("err_ignore_count", 32'(word_count), 32'd4);
    start();
    chk("err_exit_count", 32'(word_count), 32'd0);
    chk("err_exit_err", {31'b0, err}, 32'd0);
    chk("err_exit_ld_ready", {31'b0, bus.ld_ready}, 32'd1);

    // Asynchronous reset mid-load, then a full reload.
    send(32'h51, 1'b0);
    send(32'h52, 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h53;
    reset = 1'b1;
    #1 chk_reset_vals("arst");
    tick();
    tick();
    reset = 1'b0;
    bus.ld_valid = 1'b0;
    chk("arst_partial_mem04", rd(32'h04), 32'h52);
    tick();
    start();
    send(32'hF0, 1'b0);
    send(32'hF1, 1'b0);
    send(32'hF2, 1'b0);
    send(32'hF3, 1'b1);
    tick();
    tick();
    chk("reload_done", {31'b0, done}, 32'd1);
    chk("reload_count", 32'(word_count), 32'd4);
    chk("reload_mem08", rd(32'h08), 32'hF2);
    chk("reload_mem0C", rd(32'h0C), 32'hF3);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
